// File: rtl/pulse_handshake_tx.sv
// Multi-channel source-side pulse handshake engine for 1-bit CDC.
// Each channel queues pulses in a saturating counter and issues one req/ack handshake per pulse.
module pulse_handshake_tx #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned MODE        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH-1:0]         pulse_in,
  input  logic [CH-1:0]         ovf_clr,
  input  logic [CH-1:0]         ack_in,
  output logic [CH-1:0]         req_out,
  output logic [CH-1:0]         busy,
  output logic [CH*CNT_W-1:0]   pending,
  output logic [CH-1:0]         overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_WAIT    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar i = 0; i < int'(CH); i++) begin : g_ch
    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic                   busy_q, busy_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       pend_q, pend_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   start;
    logic                   consume;
    logic                   inc;
    logic                   drop;

    // ack synchroniser; only its last stage is seen by the FSM
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in[i]};
      end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        req_q   <= 1'b0;
        busy_q  <= 1'b0;
        ovf_q   <= 1'b0;
        pend_q  <= '0;
      end else begin
        state_q <= state_d;
        req_q   <= req_d;
        busy_q  <= busy_d;
        ovf_q   <= ovf_d;
        pend_q  <= pend_d;
      end
    end

    always_comb begin
      state_d = state_q;
      req_d   = req_q;
      pend_d  = pend_q;
      ovf_d   = ovf_q;

      start   = (state_q == ST_IDLE) && ((pend_q != '0) || pulse_in[i]);
      // an idle channel with nothing queued launches the new pulse directly
      consume = start && (pend_q == '0);
      inc     = pulse_in[i] && !consume;
      drop    = pulse_in[i] && (pend_q == CNT_MAX) && !start;

      if (inc && !start) begin
        if (pend_q != CNT_MAX) begin
          pend_d = pend_q + CNT_W'(1);
        end
      end else if (!inc && start && !consume) begin
        pend_d = pend_q - CNT_W'(1);
      end

      if (drop) begin
        ovf_d = 1'b1;
      end else if (ovf_clr[i]) begin
        ovf_d = 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (MODE == 0) begin
              state_d = ST_REQ;
              req_d   = 1'b1;
            end else begin
              state_d = ST_WAIT;
              req_d   = ~req_q;
            end
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            state_d = ST_RELEASE;
            req_d   = 1'b0;
          end
        end
        ST_RELEASE: begin
          if (!ack_s) begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (ack_s == req_q) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      busy_d = (state_d != ST_IDLE);
    end

    assign req_out[i]                 = req_q;
    assign busy[i]                    = busy_q;
    assign overflow[i]                = ovf_q;
    assign pending[i*CNT_W +: CNT_W]  = pend_q;
  end

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Bench for pulse_handshake_tx: a four-phase instance (CNT_W=3) and a two-phase instance (CNT_W=2),
// each driven by a delayed-mirror remote and checked every cycle against a rule-level model.
module tb_pulse_handshake_tx;
  localparam int unsigned CH      = 4;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned AW      = 3;
  localparam int unsigned BW      = 2;
  localparam int unsigned DLY_MAX = 4;

  logic clk;
  logic rst_n;
  logic [CH-1:0]    pulse_a, clr_a, ack_a, req_a, busy_a, ovf_a;
  logic [CH*AW-1:0] pend_a;
  logic [CH-1:0]    pulse_b, clr_b, ack_b, req_b, busy_b, ovf_b;
  logic [CH*BW-1:0] pend_b;

  pulse_handshake_tx #(.CH(CH), .SYNC_STAGES(SYNC), .CNT_W(AW), .MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_a), .ovf_clr(clr_a), .ack_in(ack_a),
    .req_out(req_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a));

  pulse_handshake_tx #(.CH(CH), .SYNC_STAGES(SYNC), .CNT_W(BW), .MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_b), .ovf_clr(clr_b), .ack_in(ack_b),
    .req_out(req_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference state: index 0 = four-phase instance, 1 = two-phase instance
  int m_pend [2][CH];
  bit m_busy [2][CH];
  bit m_req  [2][CH];
  bit m_seen [2][CH];
  bit m_ovf  [2][CH];
  bit s_hist [2][CH][SYNC];
  bit r_hist [2][CH][DLY_MAX];
  int r_dly  [2][CH];
  bit r_hold [2][CH];

  int n_cmp;
  int n_bad;
  int rises_a1;
  bit prev_a1;

  function automatic int maxv(input int d);
    return (d == 0) ? 7 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int d, input logic [CH-1:0] p, input logic [CH-1:0] c,
                            input logic [CH-1:0] ak);
    bit as;
    bit st;
    int nxt;
    for (int ch = 0; ch < int'(CH); ch++) begin
      as = s_hist[d][ch][SYNC-1];
      for (int k = int'(SYNC) - 1; k > 0; k--) s_hist[d][ch][k] = s_hist[d][ch][k-1];
      s_hist[d][ch][0] = ak[ch];
      st = !m_busy[d][ch] && (m_pend[d][ch] > 0 || p[ch]);
      if (st) begin
        m_busy[d][ch] = 1'b1;
        m_seen[d][ch] = 1'b0;
        m_req[d][ch]  = (d == 1) ? !m_req[d][ch] : 1'b1;
      end else if (m_busy[d][ch]) begin
        if (d == 0) begin
          if (!m_seen[d][ch]) begin
            if (as) begin
              m_seen[d][ch] = 1'b1;
              m_req[d][ch]  = 1'b0;
            end
          end else if (!as) begin
            m_busy[d][ch] = 1'b0;
          end
        end else if (as == m_req[d][ch]) begin
          m_busy[d][ch] = 1'b0;
        end
      end
      nxt = m_pend[d][ch] + int'(p[ch]) - int'(st);
      if (nxt > maxv(d)) begin
        nxt = maxv(d);
        m_ovf[d][ch] = 1'b1;
      end else if (c[ch]) begin
        m_ovf[d][ch] = 1'b0;
      end
      m_pend[d][ch] = nxt;
    end
  endtask

  task automatic check_all();
    logic [CH-1:0]    er, eb, eo, fr, fb, fo;
    logic [CH*AW-1:0] epa;
    logic [CH*BW-1:0] epb;
    for (int ch = 0; ch < int'(CH); ch++) begin
      er[ch] = m_req[0][ch];  eb[ch] = m_busy[0][ch];  eo[ch] = m_ovf[0][ch];
      fr[ch] = m_req[1][ch];  fb[ch] = m_busy[1][ch];  fo[ch] = m_ovf[1][ch];
      epa[ch*AW +: AW] = AW'(m_pend[0][ch]);
      epb[ch*BW +: BW] = BW'(m_pend[1][ch]);
    end
    chk("A.req", 32'(req_a), 32'(er));
    chk("A.busy", 32'(busy_a), 32'(eb));
    chk("A.ovf", 32'(ovf_a), 32'(eo));
    chk("A.pend", 32'(pend_a), 32'(epa));
    chk("B.req", 32'(req_b), 32'(fr));
    chk("B.busy", 32'(busy_b), 32'(fb));
    chk("B.ovf", 32'(ovf_b), 32'(fo));
    chk("B.pend", 32'(pend_b), 32'(epb));
    if (req_a[1] && !prev_a1) rises_a1++;
    prev_a1 = req_a[1];
  endtask

  // remote end: ack mirrors req after r_dly cycles unless held low
  task automatic remote_update();
    bit r;
    bit a;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < int'(CH); ch++) begin
        r = (d == 0) ? req_a[ch] : req_b[ch];
        for (int k = int'(DLY_MAX) - 1; k > 0; k--) r_hist[d][ch][k] = r_hist[d][ch][k-1];
        r_hist[d][ch][0] = r;
        a = r_hold[d][ch] ? 1'b0 : r_hist[d][ch][r_dly[d][ch]-1];
        if (d == 0) ack_a[ch] = a;
        else        ack_b[ch] = a;
      end
    end
  endtask

  task automatic step(input logic [CH-1:0] pa, input logic [CH-1:0] ca,
                      input logic [CH-1:0] pb, input logic [CH-1:0] cb);
    pulse_a = pa; clr_a = ca; pulse_b = pb; clr_b = cb;
    @(posedge clk);
    model_edge(0, pa, ca, ack_a);
    model_edge(1, pb, cb, ack_b);
    #1;
    check_all();
    remote_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && (busy_a != '0 || busy_b != '0 || pend_a != '0 || pend_b != '0); i++)
      step('0, '0, '0, '0);
    chk({tag, ".drain_busy"}, 32'({busy_a, busy_b}), 32'(0));
    chk({tag, ".drain_pend"}, 32'({pend_a, pend_b}), 32'(0));
  endtask

  task automatic do_reset();
    pulse_a = '0; clr_a = '0; pulse_b = '0; clr_b = '0;
    rst_n = 1'b0;
    ack_a = '0; ack_b = '0;
    #2;
    chk("rst.req", 32'({req_a, req_b}), 32'(0));
    chk("rst.busy", 32'({busy_a, busy_b}), 32'(0));
    chk("rst.ovf", 32'({ovf_a, ovf_b}), 32'(0));
    chk("rst.pend", 32'({pend_a, pend_b}), 32'(0));
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < int'(CH); ch++) begin
        m_pend[d][ch] = 0; m_busy[d][ch] = 0; m_req[d][ch] = 0; m_seen[d][ch] = 0; m_ovf[d][ch] = 0;
        r_hold[d][ch] = 0;
        for (int k = 0; k < int'(SYNC); k++) s_hist[d][ch][k] = 0;
        for (int k = 0; k < int'(DLY_MAX); k++) r_hist[d][ch][k] = 0;
      end
    end
    prev_a1 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; rises_a1 = 0; prev_a1 = 1'b0;
    rst_n = 1'b1;
    pulse_a = '0; clr_a = '0; ack_a = '0; pulse_b = '0; clr_b = '0; ack_b = '0;
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < int'(CH); ch++) r_dly[d][ch] = 1;
    #3;
    do_reset();

    // single pulse on the four-phase instance: req rises on the sampling edge
    step(4'b0001, '0, '0, '0);
    chk("single.req_now", 32'(req_a[0]), 32'(1));
    idle(12);
    drain("single");

    // burst of five on ch1: first pulse launches, the rest queue
    rises_a1 = 0;
    for (int k = 0; k < 5; k++) begin
      step(4'b0010, '0, '0, '0);
      chk("burst.pend", 32'(pend_a[1*AW +: AW]), 32'(k));
    end
    drain("burst");
    chk("burst.rises", 32'(rises_a1), 32'(5));

    // overflow on the two-phase instance (CNT_W=2) with ack held low
    r_hold[1][1] = 1'b1; ack_b[1] = 1'b0;
    for (int k = 0; k < 5; k++) step('0, '0, 4'b0010, '0);
    chk("ovf.pend", 32'(pend_b[1*BW +: BW]), 32'(3));
    chk("ovf.set", 32'(ovf_b[1]), 32'(1));
    step('0, '0, '0, 4'b0010);
    chk("ovf.clr", 32'(ovf_b[1]), 32'(0));
    step('0, '0, 4'b0010, 4'b0010);
    chk("ovf.set_wins", 32'(ovf_b[1]), 32'(1));
    step('0, '0, '0, 4'b0010);

    // pulse in the first idle cycle with the queue full: no drop, count holds at MAX
    r_hold[1][1] = 1'b0;
    for (int i = 0; i < 100 && busy_b[1]; i++) step('0, '0, '0, '0);
    chk("full.idle_seen", 32'(busy_b[1]), 32'(0));
    step('0, '0, 4'b0010, '0);
    chk("full.pend", 32'(pend_b[1*BW +: BW]), 32'(3));
    chk("full.no_ovf", 32'(ovf_b[1]), 32'(0));
    chk("full.restart", 32'(busy_b[1]), 32'(1));
    drain("full");

    // two-phase ch2, three pulses: req toggles 0->1->0->1
    r_dly[1][2] = 2;
    for (int k = 0; k < 3; k++) step('0, '0, 4'b0100, '0);
    drain("toggle");
    chk("toggle.req", 32'(req_b[2]), 32'(1));
    chk("toggle.busy", 32'(busy_b[2]), 32'(0));

    // every channel on both instances at once
    for (int ch = 0; ch < int'(CH); ch++) begin
      r_dly[0][ch] = ch + 1;
      r_dly[1][ch] = int'(DLY_MAX) - ch;
    end
    step(4'hf, '0, 4'hf, '0);
    step(4'hf, '0, 4'hf, '0);
    drain("all");

    // randomized traffic, clears, remote stalls and delay changes
    for (int i = 0; i < 1500; i++) begin
      logic [CH-1:0] pa, ca, pb, cb;
      for (int ch = 0; ch < int'(CH); ch++) begin
        pa[ch] = ($urandom_range(4) == 0);
        pb[ch] = ($urandom_range(4) == 0);
        ca[ch] = ($urandom_range(15) == 0);
        cb[ch] = ($urandom_range(15) == 0);
        for (int d = 0; d < 2; d++) begin
          if ($urandom_range(99) == 0) r_hold[d][ch] = !r_hold[d][ch];
          if ($urandom_range(199) == 0) r_dly[d][ch] = int'($urandom_range(DLY_MAX - 1)) + 1;
        end
      end
      step(pa, ca, pb, cb);
    end
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < int'(CH); ch++) r_hold[d][ch] = 1'b0;
    drain("rand");

    // reset in the middle of a request with two pulses queued
    r_dly[0][0] = 3;
    for (int k = 0; k < 3; k++) step(4'b0001, '0, '0, '0);
    chk("midrst.pend", 32'(pend_a[AW-1:0]), 32'(2));
    chk("midrst.req", 32'(req_a[0]), 32'(1));
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step('0, '0, '0, '0);
      chk("postrst.quiet", 32'({req_a, req_b}), 32'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
